gnn_mac_sched: RTL
==================

Name: gnn_mac_sched

Overview:
- Round-robin scheduler that shares one 4-input MAC node datapath between NUM_REQ graph-node requesters.
- Grants one requester per cycle, muxes its feature vector onto the MAC x-inputs and pulses the MAC in_ready.
- Tracks each issued job through the MAC's fixed pipeline latency and returns a per-requester done pulse.
- Provides a flush/drain sequence used by the layer controller between weight reloads.

Parameters:
- IN_SIZE, 5, signed width of each feature element x0..x3.
- NUM_REQ, 4, number of requesters (2..8).
- LAT, 3, cycles from mac_in_ready high to mac_out_ready high; must match the MAC node's pipeline.
- MAX_INFLIGHT, 3, maximum jobs outstanding in the MAC (1..LAT).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  request per requester; held high with its x data until granted.
- x_in  in  NUM_REQ*4*IN_SIZE  requester r's x0..x3 at bits [r*4*IN_SIZE +: 4*IN_SIZE], x0 in the LSBs.
- grant  out  NUM_REQ  one-hot, registered; high one cycle when the job is issued.
- mac_x  out  4*IN_SIZE  registered x0..x3 to the MAC; valid when mac_in_ready=1.
- mac_in_ready  out  1  registered issue strobe to the MAC.
- mac_out_ready  in  1  MAC result-valid (out0_ready).
- done  out  NUM_REQ  one-hot, registered; result for that requester is on the MAC outputs.
- flush  in  1  level request to stop issuing and drain.
- flush_done  out  1  one-cycle pulse when the drain completes.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky pipeline mismatch flag; cleared only by reset.

Behaviour:
- Reset (async assert, sync deassert): grant=0, mac_x=0, mac_in_ready=0, done=0, flush_done=0, busy=0, err=0.
  - Reset also clears the RR pointer (starts at requester 0), the tag pipeline and the in-flight count to 0; state=IDLE.
  - Jobs in flight at reset are dropped and produce no done.
- Arbitration, evaluated in cycle c:
  - eligible = req & ~grant. The previous grant is masked so a requester is never granted twice for one request.
  - Winner is the first eligible index at or above ptr, wrapping modulo NUM_REQ.
  - Issue is allowed only if state=RUN, flush=0 and inflight < MAX_INFLIGHT.
  - On issue, at edge c+1: grant[w]=1, mac_in_ready=1, mac_x=x_in slice w, ptr=(w+1) mod NUM_REQ.
  - With no issue: grant=0 and mac_in_ready=0. mac_x holds its last value.
- Requester contract: deassert req (or present the next job) in the cycle after its grant is seen.
- Tag pipeline:
  - An LAT-deep shift register of {valid, id}. Stage 0 is loaded with the issue tag when mac_in_ready=1.
  - The tail entry is compared against mac_out_ready in the same cycle.
  - Tail valid and mac_out_ready=1: done[id]=1 at the next edge, i.e. done appears LAT+1 cycles after grant.
  - Tail valid xor mac_out_ready: err set (sticky). A valid tail is still retired, with no done.
- inflight: +1 on issue, -1 on retire. Both in the same cycle: unchanged. Never exceeds MAX_INFLIGHT; never underflows.
- FSM:
  - IDLE: busy=0. Any req -> RUN. Else flush=1 -> DRAIN.
  - RUN: issues per the arbitration rules. flush=1 -> DRAIN (no issue in that cycle). inflight=0 and req=0 -> IDLE.
  - DRAIN: no issue. When inflight=0 and no retire pending: flush_done=1 for one cycle -> IDLE.
  - flush is still sampled during the flush_done cycle. If flush is still high in IDLE, a new drain starts, with flush_done one cycle later.
- Widths: all counters are sized to clog2(MAX_INFLIGHT+1). The ptr wraps from NUM_REQ-1 to 0.

Test Plan:
- Single job:
  - Stimulus: reset; req=4'b0100, x_in slice2 = {x3..x0} = {-1, 2, 3, -16}.
  - Required: grant=4'b0100 and mac_in_ready at cycle 1; mac_x matches slice 2; model MAC returns out_ready at cycle 4; done=4'b0100 at cycle 5; busy then returns to 0.
- Fairness:
  - Stimulus: req=4'b1111 held, each requester re-raising after its grant; MAX_INFLIGHT=3.
  - Required: grant order 0,1,2,3,0,... with gaps where inflight=3; each done arrives 4 cycles after its grant in the same order.
- Back-pressure:
  - Stimulus: MAX_INFLIGHT=1, req=4'b0011.
  - Required: at most one job outstanding; grants are at least LAT+1 cycles apart; no err.
- Flush mid-stream:
  - Stimulus: assert flush two cycles after three grants.
  - Required: no further grant; flush_done pulses once, one cycle after the last done; then IDLE.
- Pipeline mismatch:
  - Stimulus: the model MAC drops one out_ready.
  - Required: err=1 and stays set; no done for the dropped job; inflight returns to 0.
- Async reset during DRAIN with 2 jobs in flight:
  - Required: all outputs are 0 immediately; no done and no flush_done after release; the next req is granted starting from requester 0.

Source files
------------

// File: rtl/gnn_mac_sched_if.sv
// Requester-side and MAC-side bus of the shared MAC scheduler.
interface gnn_mac_sched_if #(
  parameter int unsigned IN_SIZE = 5,
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*4*IN_SIZE-1:0] x_in;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           done;
  logic [4*IN_SIZE-1:0]         mac_x;
  logic                         mac_in_ready;
  logic                         mac_out_ready;

  modport master (output req, x_in, mac_out_ready, input grant, done, mac_x, mac_in_ready);
  modport slave  (input req, x_in, mac_out_ready, output grant, done, mac_x, mac_in_ready);
endinterface

// File: rtl/gnn_mac_sched.sv
// Round-robin scheduler sharing one 4-input MAC node between NUM_REQ requesters,
// tracking each job through the MAC latency and draining on flush.
module gnn_mac_sched #(
  parameter int unsigned IN_SIZE      = 5,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned LAT          = 3,
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  gnn_mac_sched_if.slave  bus,
  input  logic            flush,
  output logic            flush_done,
  output logic            busy,
  output logic            err
);
  localparam int unsigned XW = 4 * IN_SIZE;
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

  typedef struct packed {
    logic          valid;
    logic [PW-1:0] id;
  } tag_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d, issue_id_q, issue_id_d, win;
  logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d, eligible;
  logic [XW-1:0]      mac_x_q, mac_x_d, win_x;
  logic               mac_in_ready_q, mac_in_ready_d;
  logic               flush_done_q, flush_done_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [CW-1:0]      inflight_q, inflight_d;
  tag_t               tag_q [LAT];
  tag_t               tag_d [LAT];
  logic               found, issue, retire, pipe_busy, drain_ok;

  // Winner search starting at ptr; the last grant is masked to avoid double issue.
  always_comb begin
    eligible = bus.req & ~grant_q;
    found    = 1'b0;
    win      = '0;
    win_x    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && eligible[PW'((32'(ptr_q) + i) % NUM_REQ)]) begin
        found = 1'b1;
        win   = PW'((32'(ptr_q) + i) % NUM_REQ);
      end
    end
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (PW'(r) == win) win_x = bus.x_in[r*XW +: XW];
    end
  end

  always_comb begin
    retire    = tag_q[LAT-1].valid;
    pipe_busy = mac_in_ready_q;
    for (int unsigned i = 0; i < LAT; i++) begin
      pipe_busy = pipe_busy | tag_q[i].valid;
    end
    drain_ok = (inflight_q == '0) && !pipe_busy;
    issue    = (state_q == S_RUN) && !flush && (inflight_q < CW'(MAX_INFLIGHT)) && found;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req)  state_d = S_RUN;
        else if (flush) state_d = S_DRAIN;
      end
      S_RUN: begin
        if (flush)                                   state_d = S_DRAIN;
        else if ((inflight_q == '0) && !(|bus.req))  state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (drain_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    grant_d        = '0;
    mac_in_ready_d = 1'b0;
    mac_x_d        = mac_x_q;
    ptr_d          = ptr_q;
    issue_id_d     = issue_id_q;
    if (issue) begin
      grant_d        = NUM_REQ'(1) << win;
      mac_in_ready_d = 1'b1;
      mac_x_d        = win_x;
      ptr_d          = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
      issue_id_d     = win;
    end

    tag_d[0].valid = mac_in_ready_q;
    tag_d[0].id    = issue_id_q;
    for (int unsigned i = 1; i < LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    // A valid tail always retires; only a matched out_ready yields done.
    done_d = (retire && bus.mac_out_ready) ? (NUM_REQ'(1) << tag_q[LAT-1].id) : '0;
    err_d  = err_q | (retire ^ bus.mac_out_ready);

    case ({issue, retire})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = (inflight_q != '0) ? inflight_q - CW'(1) : inflight_q;
      default: inflight_d = inflight_q;
    endcase

    flush_done_d = (state_q == S_DRAIN) && drain_ok;
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q        <= '0;
      mac_in_ready_q <= 1'b0;
      mac_x_q        <= '0;
      ptr_q          <= '0;
      issue_id_q     <= '0;
      done_q         <= '0;
      err_q          <= 1'b0;
      inflight_q     <= '0;
      flush_done_q   <= 1'b0;
      busy_q         <= 1'b0;
      for (int unsigned i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      grant_q        <= grant_d;
      mac_in_ready_q <= mac_in_ready_d;
      mac_x_q        <= mac_x_d;
      ptr_q          <= ptr_d;
      issue_id_q     <= issue_id_d;
      done_q         <= done_d;
      err_q          <= err_d;
      inflight_q     <= inflight_d;
      flush_done_q   <= flush_done_d;
      busy_q         <= busy_d;
      for (int unsigned i = 0; i < LAT; i++) tag_q[i] <= tag_d[i];
    end
  end

  assign bus.grant        = grant_q;
  assign bus.mac_in_ready = mac_in_ready_q;
  assign bus.mac_x        = mac_x_q;
  assign bus.done         = done_q;
  assign flush_done       = flush_done_q;
  assign busy             = busy_q;
  assign err              = err_q;
endmodule
